// File: rtl/serial_alu.sv
// Multi-cycle ALU: WIDTH-bit operands processed STEP bits per clock through one slice with a registered carry.
// Define SERIAL_ALU_FLAGS_EN to build the overflow and zero flag logic; otherwise both flags are tied low.
module serial_alu #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [3:0]       Opcode,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [3:0]       r_op;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [STEP-1:0]  w_a;
  logic [STEP-1:0]  w_b;
  logic [STEP-1:0]  w_chunk;
  logic [STEP:0]    w_sum;
  logic             w_is_sub;
  logic             w_is_arith;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;

  // Next-state logic; a start is only accepted outside RUN.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next   = S_RUN;
          w_accept = 1'b1;
        end else begin
          w_next   = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == LAST) begin
          w_next = S_DONE;
          w_last = 1'b1;
        end else begin
          w_next = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_RUN);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Shared slice: subtract is A + ~B with the inverted borrow preloaded into the carry register.
  always_comb begin
    w_is_sub   = (r_op == OP_SUB);
    w_is_arith = (r_op == OP_ADD) || w_is_sub;
    w_a        = r_a[STEP-1:0];
    w_b        = w_is_sub ? ~r_b[STEP-1:0] : r_b[STEP-1:0];
    w_sum      = {1'b0, w_a} + {1'b0, w_b} + (STEP+1)'(r_carry);
    case (r_op)
      OP_ADD, OP_SUB: w_chunk = w_sum[STEP-1:0];
      OP_AND:         w_chunk = w_a & w_b;
      OP_OR:          w_chunk = w_a | w_b;
      OP_XOR:         w_chunk = w_a ^ w_b;
      default:        w_chunk = {STEP{1'b0}};
    endcase
    w_cout     = w_is_sub ? ~w_sum[STEP] : (w_is_arith & w_sum[STEP]);
    w_res_next = (r_res >> STEP) | (WIDTH'(w_chunk) << (WIDTH - STEP));
  end

  // Operand capture, chunk sequencing and result/carry registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_res   <= {WIDTH{1'b0}};
      r_op    <= 4'b0000;
      r_carry <= 1'b0;
      r_cnt   <= {CW{1'b0}};
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_op    <= Opcode;
      r_carry <= (Opcode == OP_SUB) ? ~Cin : ((Opcode == OP_ADD) ? Cin : 1'b0);
      r_cnt   <= {CW{1'b0}};
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> STEP;
      r_b     <= r_b >> STEP;
      r_res   <= w_res_next;
      r_carry <= w_sum[STEP];
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_cout <= w_cout;
      end
    end
  end

`ifdef SERIAL_ALU_FLAGS_EN
  logic r_zacc;
  logic r_ovf;
  logic r_zero;
  logic w_valid;
  logic w_msb_cin;

  // Carry into the slice MSB is recovered from the sum bit, so no extra split adder is needed.
  always_comb begin
    w_valid   = w_is_arith || (r_op == OP_AND) || (r_op == OP_OR) || (r_op == OP_XOR);
    w_msb_cin = w_a[STEP-1] ^ w_b[STEP-1] ^ w_sum[STEP-1];
  end

  // Zero accumulator and final overflow/zero flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zacc <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_zacc <= 1'b1;
    end else if (r_state == S_RUN) begin
      if (|w_chunk) begin
        r_zacc <= 1'b0;
      end
      if (w_last) begin
        r_ovf  <= w_is_arith & (w_msb_cin ^ w_sum[STEP]);
        r_zero <= w_valid & r_zacc & ~(|w_chunk);
      end
    end
  end

  assign overflow = r_ovf;
  assign zero     = r_zero;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

  assign result    = r_res;
  assign carry_out = r_cout;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
